// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write arbiter: FSM state encoding,
// default parameter values and a small width helper.
package fifo_arb_pkg;

   // FSM state encoding (kept as plain constants for legacy compatibility)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // Default parameter values
   localparam int unsigned DEF_NUM_OF_WORDS = 32;
   localparam int unsigned DEF_WORD_LENGTH  = 8;
   localparam int unsigned DEF_NUM_REQ      = 4;

   // Width of each per-requester grant statistics counter
   localparam int unsigned STATS_W = 16;

   // Width of a requester index; never zero, even for a single requester
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin winner selection: searches the request vector starting at
// the pointer position and returns the first requester found, both as a
// one-hot vector and as an index.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned num_req = DEF_NUM_REQ,
   parameter int unsigned ptr_w   = ptr_width(DEF_NUM_REQ)
) (
   input  logic [num_req-1:0] req,
   input  logic [ptr_w-1:0]   ptr,
   output logic [num_req-1:0] winner,
   output logic [ptr_w-1:0]   winner_idx,
   output logic               valid
);

   logic [ptr_w-1:0] idx;

   // Rotating priority search: first asserted request at or after ptr
   always_comb begin
      winner     = '0;
      winner_idx = '0;
      valid      = 1'b0;
      idx        = '0;
      for (int unsigned k = 0; k < num_req; k++) begin
         idx = ptr_w'((32'(ptr) + k) % num_req);
         if (!valid && req[idx]) begin
            valid       = 1'b1;
            winner[idx] = 1'b1;
            winner_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// FIFO write arbiter: merges several write requesters onto one FIFO write
// port using round-robin arbitration, tracks a shadow occupancy count so
// no write is issued into a full FIFO, and flags overflow if the FIFO
// itself reports full while a write is in flight.
// Optional feature macro: FIFO_ARB_STATS_EN adds per-requester saturating
// grant counters on output grant_count.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned num_of_words = DEF_NUM_OF_WORDS,
   parameter int unsigned word_length  = DEF_WORD_LENGTH,
   parameter int unsigned num_req      = DEF_NUM_REQ
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [num_req-1:0]              req,
   input  logic [num_req*word_length-1:0]  req_data,
   input  logic                            read_from_stack,
   input  logic                            stack_full,
   output logic [num_req-1:0]              gnt,
   output logic                            write_to_stack,
   output logic [word_length-1:0]          data_in,
   output logic                            overflow_err
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [num_req*STATS_W-1:0]      grant_count
`endif
);

   localparam int unsigned   CW         = $clog2(num_of_words) + 1;
   localparam int unsigned   PW         = ptr_width(num_req);
   localparam logic [CW-1:0] FULL_LEVEL = CW'(num_of_words);
   localparam logic [PW-1:0] LAST_REQ   = PW'(num_req - 1);

   logic [CW-1:0]      count;
   logic [1:0]         state;
   logic [1:0]         state_next;
   logic [PW-1:0]      ptr;
   logic [num_req-1:0] pick;
   logic [PW-1:0]      pick_idx;
   logic               pick_valid;
   logic               room;
   logic               issue;
   logic               drain;

   rr_pick #(
      .num_req (num_req),
      .ptr_w   (PW)
   ) u_pick (
      .req        (req),
      .ptr        (ptr),
      .winner     (pick),
      .winner_idx (pick_idx),
      .valid      (pick_valid)
   );

   // Write decision uses the registered count only, so a read in the same
   // cycle frees a slot for the following decision, never the current one.
   always_comb begin
      room  = (count < FULL_LEVEL);
      issue = pick_valid & room;
      drain = read_from_stack & (count != '0);
   end

   // Next FSM state: WRITE exactly when a write is issued at this edge
   always_comb begin
      state_next = ST_IDLE;
      if (pick_valid) begin
         state_next = room ? ST_WRITE : ST_FULL;
      end else if (state == ST_FULL && !room) begin
         state_next = ST_FULL;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Shadow occupancy: +1 per issued write, -1 per read while non-empty
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (issue && !drain) begin
         count <= count + 1'b1;
      end else if (!issue && drain) begin
         count <= count - 1'b1;
      end
   end

   // Round-robin pointer moves to the requester after the last winner
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (issue) begin
         ptr <= (pick_idx == LAST_REQ) ? '0 : pick_idx + 1'b1;
      end
   end

   // Registered write strobe and grant, valid for the cycle after the decision
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_to_stack <= 1'b0;
         gnt            <= '0;
      end else begin
         write_to_stack <= issue;
         gnt            <= issue ? pick : '0;
      end
   end

   // Registered write data; holds its last value between writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_in <= '0;
      end else if (issue) begin
         data_in <= req_data[pick_idx*word_length +: word_length];
      end
   end

   // Sticky overflow: the FIFO claimed full while our write was on the port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_err <= 1'b0;
      end else if (stack_full && write_to_stack) begin
         overflow_err <= 1'b1;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   for (genvar i = 0; i < num_req; i++) begin : g_stats
      logic [STATS_W-1:0] cnt;

      // Saturating per-requester grant counter
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt <= '0;
         end else if (issue && pick[i] && cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end

      assign grant_count[i*STATS_W +: STATS_W] = cnt;
   end
`endif

endmodule
